// File: rtl/traceback_unit.sv
`default_nettype none
// ============================================================================
// Module   : traceback_unit
// Brief    : Captures PE pointer wavefronts, then walks them backwards and
//            streams the alignment as M/D/I edit operations.
// Revision : 1.0 - initial release
// ============================================================================
module traceback_unit #(
  parameter int B = 4,
  parameter int L = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           in_valid,
  input  logic           in_last,
  input  logic [3*B-1:0] ptr_in,
  input  logic           op_ready,
  output logic           op_valid,
  output logic [1:0]     op_code,
  output logic           op_last,
  output logic           done,
  output logic           err,
  output logic           busy
);

  localparam int DEPTH = 2 * L;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCW   = AW + 1;
  localparam int WW    = 9;
  localparam int KIDX  = (B > 1) ? $clog2(B) : 1;
  localparam int KW    = KIDX + 2;

  localparam logic signed [KW-1:0] K_MAX = KW'(B - 1);
  localparam logic signed [KW-1:0] K_ONE = KW'(1);
  localparam logic signed [WW-1:0] W_ONE = WW'(1);
  localparam logic signed [WW-1:0] W_TWO = WW'(2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_TRACE   = 2'd2,
    S_FIN     = 2'd3
  } state_t;

  // Encodings double as the op_code driven downstream.
  typedef enum logic [1:0] {
    MV_DIAG = 2'b00,
    MV_UP   = 2'b01,
    MV_LEFT = 2'b10,
    MV_NONE = 2'b11
  } move_t;

  state_t                state_q, state_d;
  logic [WCW-1:0]        wc_q, wc_d;
  logic signed [WW-1:0]  w_q, w_d;
  logic signed [KW-1:0]  k_q, k_d;
  logic                  err_flag_q, err_flag_d;
  logic                  wr_en;

  logic [3*B-1:0]        mem_q [DEPTH];
  logic [3*B-1:0]        rd_word;
  logic [2:0]            lane_ptr [B];
  logic [2:0]            cur_ptr;
  move_t                 mv;
  logic signed [WW-1:0]  next_w;
  logic signed [KW-1:0]  next_k;
  logic                  mv_last;
  logic                  k_ok;

  // Pointer storage: no reset, only the captured span is ever read.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_q[wc_q[AW-1:0]] <= ptr_in;
    end
  end

  assign rd_word = mem_q[w_q[AW-1:0]];

  for (genvar g = 0; g < B; g++) begin : g_lane
    assign lane_ptr[g] = rd_word[3*g +: 3];
  end

  assign cur_ptr = lane_ptr[k_q[KIDX-1:0]];

  always_comb begin
    mv = MV_NONE;
    case (cur_ptr)
      3'b001, 3'b101: mv = MV_DIAG;
      3'b010, 3'b110: mv = MV_UP;
      3'b011, 3'b100: mv = MV_LEFT;
      default:        mv = MV_NONE;
    endcase
  end

  // Lane shift on vertical/horizontal moves depends on the parity of w.
  always_comb begin
    next_w = w_q;
    next_k = k_q;
    case (mv)
      MV_DIAG: begin
        next_w = w_q - W_TWO;
      end
      MV_UP: begin
        next_w = w_q - W_ONE;
        next_k = w_q[0] ? k_q : (k_q - K_ONE);
      end
      MV_LEFT: begin
        next_w = w_q - W_ONE;
        next_k = w_q[0] ? (k_q + K_ONE) : k_q;
      end
      default: begin
        next_w = w_q;
        next_k = k_q;
      end
    endcase
  end

  assign mv_last = next_w[WW-1];
  assign k_ok    = !next_k[KW-1] && (next_k <= K_MAX);

  always_comb begin
    state_d    = state_q;
    wc_d       = wc_q;
    w_d        = w_q;
    k_d        = k_q;
    err_flag_d = err_flag_q;
    wr_en      = 1'b0;
    op_valid   = 1'b0;
    op_code    = 2'b00;
    op_last    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CAPTURE;
          wc_d       = '0;
          err_flag_d = 1'b0;
        end
      end

      S_CAPTURE: begin
        if (in_valid) begin
          wr_en = 1'b1;
          wc_d  = wc_q + WCW'(1);
          if (in_last || (wc_q == WCW'(DEPTH - 1))) begin
            state_d = S_TRACE;
            w_d     = $signed({{(WW-WCW){1'b0}}, wc_q});
            k_d     = K_MAX;
          end
        end
      end

      S_TRACE: begin
        if ((mv == MV_NONE) || (!mv_last && !k_ok)) begin
          state_d    = S_FIN;
          err_flag_d = 1'b1;
        end else begin
          op_valid = 1'b1;
          op_code  = mv;
          op_last  = mv_last;
          if (op_ready) begin
            if (mv_last) begin
              state_d = S_FIN;
            end else begin
              w_d = next_w;
              k_d = next_k;
            end
          end
        end
      end

      S_FIN: begin
        done       = 1'b1;
        err        = err_flag_q;
        err_flag_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wc_q       <= '0;
      w_q        <= '0;
      k_q        <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wc_q       <= wc_d;
      w_q        <= w_d;
      k_q        <= k_d;
      err_flag_q <= err_flag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traceback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_traceback_unit
// Brief    : Directed self-checking bench for traceback_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traceback_unit;

  localparam int B     = 4;
  localparam int L     = 8;
  localparam int DEPTH = 2 * L;

  localparam logic [11:0] W_DIAG  = 12'h249; // every lane 001
  localparam logic [11:0] W_UP3   = 12'h449; // lane3 010, others 001
  localparam logic [11:0] W_LEFT3 = 12'h649; // lane3 011, others 001
  localparam logic [11:0] W_L32   = 12'h6C9; // lanes 3,2 = 011, others 001
  localparam logic [11:0] W_BAD3  = 12'h049; // lane3 000, others 001

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [11:0] ptr_in;
  logic        op_ready;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        op_last;
  logic        done;
  logic        err;
  logic        busy;

  traceback_unit #(.B(B), .L(L)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_last  (in_last),
    .ptr_in   (ptr_in),
    .op_ready (op_ready),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_last  (op_last),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] words [DEPTH];

  logic [63:0] obs_codes;
  logic [31:0] obs_last;
  int          n_ops;
  int          done_cyc;
  int          last_acc;
  int          first_valid;
  int          stall_cycles;
  int          stall_bad;
  logic        obs_err;
  logic        saw_done;
  logic        busy_after;

  task automatic fill_words(input logic [11:0] base);
    for (int i = 0; i < DEPTH; i++) words[i] = base;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      ptr_in   = words[i];
      in_last  = use_last && (i == n - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Records the op stream; cycle 0 is the first cycle after the final write.
  task automatic collect(input int stall_at, input int stall_len);
    logic [1:0] hold_code;
    logic       hold_last;
    n_ops = 0; obs_codes = '0; obs_last = '0; done_cyc = -1; last_acc = -1;
    first_valid = -1; stall_cycles = 0; stall_bad = 0; obs_err = 1'b0;
    saw_done = 1'b0; hold_code = 2'b00; hold_last = 1'b0;
    for (int c = 0; c < 200 && !saw_done; c++) begin
      op_ready = !((n_ops == stall_at) && (stall_cycles < stall_len));
      #1;
      if (done) begin
        saw_done = 1'b1;
        obs_err  = err;
        done_cyc = c;
      end
      if (op_valid) begin
        if (first_valid < 0) first_valid = c;
        if ((n_ops == stall_at) && (stall_cycles > 0) &&
            ((op_code !== hold_code) || (op_last !== hold_last)))
          stall_bad++;
        if (op_ready) begin
          if (n_ops < 32) begin
            obs_codes[2*n_ops +: 2] = op_code;
            obs_last[n_ops]         = op_last;
          end
          n_ops++;
          last_acc = c;
        end else begin
          stall_cycles++;
          hold_code = op_code;
          hold_last = op_last;
        end
      end
      @(negedge clk);
    end
    #1 busy_after = busy;
    op_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    ptr_in = '0; op_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({op_valid, op_code, op_last, done, err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 0000000",
               {op_valid, op_code, op_last, done, err, busy});
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      ptr_in   = 12'h000;
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || op_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_in_valid: busy=%b op_valid=%b, expected 0 0", busy, op_valid);
      end
    end
    in_valid = 1'b0;
    op_ready = 1'b1;
  endtask

  task automatic test_all_diag();
    fill_words(W_DIAG);
    pulse_start();
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: got %b, expected 1", busy);
    end
    send_words(15, 1'b1);
    collect(-1, 0);
    checks++;
    if (!saw_done || n_ops != 8 || obs_codes !== 64'h0 || obs_last !== 32'h80) begin
      errors++;
      $display("FAIL diag_stream: done=%b ops=%0d codes=%h last=%h, expected 1 8 0 80",
               saw_done, n_ops, obs_codes, obs_last);
    end
    checks++;
    if (first_valid != 0 || done_cyc != last_acc + 1 || obs_err !== 1'b0 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL diag_timing: first=%0d done=%0d last_acc=%0d err=%b busy=%b, expected 0 last+1 0 0",
               first_valid, done_cyc, last_acc, obs_err, busy_after);
    end
  endtask

  // D at w=14 drops to lane 2, I at odd w=13 returns to lane 3, then 7 M.
  task automatic test_mixed_backpressure();
    fill_words(W_DIAG);
    words[13] = W_L32;
    words[14] = W_UP3;
    pulse_start();
    send_words(15, 1'b1);
    collect(1, 3);
    checks++;
    if (n_ops != 9 || obs_codes !== 64'h9 || obs_last !== 32'h100) begin
      errors++;
      $display("FAIL mixed_stream: ops=%0d codes=%h last=%h, expected 9 9 100",
               n_ops, obs_codes, obs_last);
    end
    checks++;
    if (stall_cycles != 3 || stall_bad != 0) begin
      errors++;
      $display("FAIL mixed_stall: stalls=%0d unstable=%0d, expected 3 0", stall_cycles, stall_bad);
    end
    checks++;
    if (!saw_done || obs_err !== 1'b0 || done_cyc != last_acc + 1) begin
      errors++;
      $display("FAIL mixed_done: done=%b err=%b done_cyc=%0d last_acc=%0d, expected 1 0 last+1",
               saw_done, obs_err, done_cyc, last_acc);
    end
  endtask

  task automatic test_lane_overflow();
    fill_words(W_DIAG);
    words[13] = W_LEFT3;
    words[14] = W_LEFT3;
    pulse_start();
    send_words(15, 1'b1);
    collect(-1, 0);
    checks++;
    if (n_ops != 1 || obs_codes !== 64'h2) begin
      errors++;
      $display("FAIL overflow_ops: ops=%0d codes=%h, expected 1 2", n_ops, obs_codes);
    end
    checks++;
    if (!saw_done || obs_err !== 1'b1 || done_cyc != 2 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL overflow_err: done=%b err=%b done_cyc=%0d busy=%b, expected 1 1 2 0",
               saw_done, obs_err, done_cyc, busy_after);
    end
  endtask

  task automatic test_invalid_code();
    fill_words(W_DIAG);
    words[14] = W_BAD3;
    pulse_start();
    send_words(15, 1'b1);
    collect(-1, 0);
    checks++;
    if (n_ops != 0 || first_valid != -1 || obs_err !== 1'b1 || done_cyc != 1) begin
      errors++;
      $display("FAIL invalid_code: ops=%0d first=%0d err=%b done_cyc=%0d, expected 0 -1 1 1",
               n_ops, first_valid, obs_err, done_cyc);
    end
  endtask

  // Word 15 only reachable if capture stopped by itself at DEPTH words.
  task automatic test_auto_stop();
    fill_words(W_DIAG);
    words[15] = W_UP3;
    pulse_start();
    send_words(16, 1'b0);
    collect(-1, 0);
    checks++;
    if (n_ops != 9 || obs_codes !== 64'h1 || obs_last !== 32'h100 || first_valid != 0) begin
      errors++;
      $display("FAIL auto_stop: ops=%0d codes=%h last=%h first=%0d, expected 9 1 100 0",
               n_ops, obs_codes, obs_last, first_valid);
    end
    checks++;
    if (!saw_done || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL auto_stop_done: done=%b err=%b, expected 1 0", saw_done, obs_err);
    end
  endtask

  task automatic test_reset_mid_trace();
    int seen;
    fill_words(W_DIAG);
    pulse_start();
    send_words(15, 1'b1);
    op_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (op_valid === 1'b1 && op_code === 2'b00) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL midtrace_pre: accepted=%0d, expected 3", seen);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (op_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midtrace_reset: op_valid=%b busy=%b, expected 0 0", op_valid, busy);
    end
    pulse_start();
    send_words(15, 1'b1);
    collect(-1, 0);
    checks++;
    if (!saw_done || n_ops != 8 || obs_codes !== 64'h0 || obs_last !== 32'h80 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL midtrace_rerun: done=%b ops=%0d codes=%h last=%h err=%b, expected 1 8 0 80 0",
               saw_done, n_ops, obs_codes, obs_last, obs_err);
    end
  endtask

  initial begin
    test_reset();
    test_all_diag();
    test_mixed_backpressure();
    test_lane_overflow();
    test_invalid_code();
    test_auto_stop();
    test_reset_mid_trace();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
